// File: rtl/conv_pkg.sv
// Shared widths, FSM states and kernel type for the 3x3 convolution stage.
package conv_pkg;
    localparam int PIX_W  = 8;
    localparam int ACC_W  = 22;
    localparam int PROD_W = 2 * PIX_W;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    typedef logic signed [PIX_W-1:0] weight_t;
    typedef weight_t [8:0] kernel_t;
endpackage

// File: rtl/conv_window_buf.sv
// Two line buffers plus a 3x3 sliding window; win[3*r+c] is row r (0 = oldest), col c (0 = leftmost).
module conv_window_buf #(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int PIX_W      = 8,
    parameter int CW         = $clog2(IMG_WIDTH),
    parameter int RW         = $clog2(IMG_HEIGHT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               accept,
    input  logic [CW-1:0]      col,
    input  logic [RW-1:0]      row,
    input  logic [PIX_W-1:0]   pixel_in,
    output logic [9*PIX_W-1:0] win,
    output logic               win_valid
);
    logic [IMG_WIDTH-1:0][PIX_W-1:0] lb1_q, lb1_d, lb2_q, lb2_d;
    logic [8:0][PIX_W-1:0]           win_q, win_d;
    logic                            win_valid_q, win_valid_d;

    always_comb begin
        lb1_d       = lb1_q;
        lb2_d       = lb2_q;
        win_d       = win_q;
        win_valid_d = 1'b0;
        if (accept) begin
            lb2_d[col] = lb1_q[col];
            lb1_d[col] = pixel_in;
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]   = win_q[3*r+1];
                win_d[3*r+1] = win_q[3*r+2];
            end
            // New right-hand column: rows r-2, r-1, r
            win_d[2]    = lb2_q[col];
            win_d[5]    = lb1_q[col];
            win_d[8]    = pixel_in;
            win_valid_d = (row >= RW'(2)) && (col >= CW'(2));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lb1_q       <= '0;
            lb2_q       <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
        end else begin
            lb1_q       <= lb1_d;
            lb2_q       <= lb2_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign win       = win_q;
    assign win_valid = win_valid_q;
endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid-mode convolution: frame FSM, window buffer, and a 2-stage multiply/sum pipeline.
module conv3x3_stream #(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int PIX_W      = conv_pkg::PIX_W,
    parameter int ACC_W      = conv_pkg::ACC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_signal,
    input  logic [9*PIX_W-1:0] kernel_in,
    input  logic               pixel_valid,
    input  logic [PIX_W-1:0]   pixel_in,
    output logic [ACC_W-1:0]   result_out,
    output logic               result_valid,
    output logic               done_signal
);
    import conv_pkg::*;

    localparam int CW  = $clog2(IMG_WIDTH);
    localparam int RW  = $clog2(IMG_HEIGHT);
    localparam int PW2 = 2 * PIX_W;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    state_t                 state_q, state_d;
    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic [8:0][PIX_W-1:0]  kern_q, kern_d;
    logic                   accept;
    logic [9*PIX_W-1:0]     win;
    logic                   win_valid;
    logic signed [PW2-1:0]  prod_q [9];
    logic signed [PW2-1:0]  prod_d [9];
    logic [1:0]             vld_pipe_q, vld_pipe_d;
    logic signed [ACC_W-1:0] result_q, result_d, sum;

    assign accept = (state_q == STREAM) && pixel_valid;

    conv_window_buf #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT),
        .PIX_W     (PIX_W),
        .CW        (CW),
        .RW        (RW)
    ) u_win (
        .clk      (clk),
        .rst      (rst),
        .accept   (accept),
        .col      (col_q),
        .row      (row_q),
        .pixel_in (pixel_in),
        .win      (win),
        .win_valid(win_valid)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        kern_d  = kern_q;
        case (state_q)
            IDLE: if (start_signal) begin
                kern_d  = kernel_in;
                col_d   = '0;
                row_d   = '0;
                state_d = STREAM;
            end
            STREAM: if (pixel_valid) begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) state_d = FLUSH;
                    else                   row_d   = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            // Result register already holds the last sum once the earlier stages drain
            FLUSH:   if (!win_valid && !vld_pipe_q[0]) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vld_pipe_d = {vld_pipe_q[0], win_valid};
        for (int i = 0; i < 9; i++)
            prod_d[i] = PW2'($signed(win[i*PIX_W +: PIX_W])) * PW2'($signed(kern_q[i]));
        sum = '0;
        for (int i = 0; i < 9; i++)
            sum = sum + ACC_W'(prod_q[i]);
        result_d = vld_pipe_q[0] ? sum : result_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            kern_q     <= '0;
            vld_pipe_q <= '0;
            result_q   <= '0;
            for (int i = 0; i < 9; i++) prod_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            kern_q     <= kern_d;
            vld_pipe_q <= vld_pipe_d;
            result_q   <= result_d;
            for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
        end
    end

    assign result_out   = result_q;
    assign result_valid = vld_pipe_q[1];
    assign done_signal  = (state_q == DONE);
endmodule
